// File: rtl/mux_4x1_pkg.sv
// Shared select encoding for the 4-to-1 gate-level multiplexer.
package mux_4x1_pkg;

  typedef enum logic [1:0] {
    SEL_I0 = 2'b00,
    SEL_I1 = 2'b01,
    SEL_I2 = 2'b10,
    SEL_I3 = 2'b11
  } sel_e;

  localparam int unsigned NUM_TERMS = 4;

endpackage

// File: rtl/mux_4x1_decode.sv
// Select decoder: inverted selects and the four one-hot product-term enables.
module mux_4x1_decode
  import mux_4x1_pkg::*;
(
  input  logic                 i_b,
  input  logic                 i_c,
  output logic                 o_nb,
  output logic                 o_nc,
  output logic [NUM_TERMS-1:0] o_en
);

  logic w_nb;
  logic w_nc;

  assign w_nb = ~i_b;
  assign w_nc = ~i_c;

  // Plain gates so X/Z on a select propagates naturally.
  assign o_en[SEL_I0] = w_nb & w_nc;
  assign o_en[SEL_I1] = w_nb & i_c;
  assign o_en[SEL_I2] = i_b  & w_nc;
  assign o_en[SEL_I3] = i_b  & i_c;

  assign o_nb = w_nb;
  assign o_nc = w_nc;

endmodule

// File: rtl/mux_4x1.sv
// 4-to-1 mux as a two-level AND/OR network with every term registered for debug.
module mux_4x1
  import mux_4x1_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] i0_in,
  input  logic [WIDTH-1:0] i1_in,
  input  logic [WIDTH-1:0] i2_in,
  input  logic [WIDTH-1:0] i3_in,
  input  logic             b_in,
  input  logic             c_in,
  output logic             nb_out,
  output logic             nc_out,
  output logic [WIDTH-1:0] a1_out,
  output logic [WIDTH-1:0] a2_out,
  output logic [WIDTH-1:0] a3_out,
  output logic [WIDTH-1:0] a4_out,
  output logic [WIDTH-1:0] y_out
);

  logic                 w_nb;
  logic                 w_nc;
  logic [NUM_TERMS-1:0] w_en;
  logic [WIDTH-1:0]     w_a1;
  logic [WIDTH-1:0]     w_a2;
  logic [WIDTH-1:0]     w_a3;
  logic [WIDTH-1:0]     w_a4;
  logic [WIDTH-1:0]     w_y;

  logic                 r_nb;
  logic                 r_nc;
  logic [WIDTH-1:0]     r_a1;
  logic [WIDTH-1:0]     r_a2;
  logic [WIDTH-1:0]     r_a3;
  logic [WIDTH-1:0]     r_a4;
  logic [WIDTH-1:0]     r_y;

  mux_4x1_decode u_decode (
    .i_b  (b_in),
    .i_c  (c_in),
    .o_nb (w_nb),
    .o_nc (w_nc),
    .o_en (w_en)
  );

  assign w_a1 = i0_in & {WIDTH{w_en[SEL_I0]}};
  assign w_a2 = i1_in & {WIDTH{w_en[SEL_I1]}};
  assign w_a3 = i2_in & {WIDTH{w_en[SEL_I2]}};
  assign w_a4 = i3_in & {WIDTH{w_en[SEL_I3]}};
  assign w_y  = w_a1 | w_a2 | w_a3 | w_a4;

  // Reset clears nb/nc to 0 as well; they are not forced to mirror the selects.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_nb <= 1'b0;
      r_nc <= 1'b0;
      r_a1 <= '0;
      r_a2 <= '0;
      r_a3 <= '0;
      r_a4 <= '0;
      r_y  <= '0;
    end else begin
      r_nb <= w_nb;
      r_nc <= w_nc;
      r_a1 <= w_a1;
      r_a2 <= w_a2;
      r_a3 <= w_a3;
      r_a4 <= w_a4;
      r_y  <= w_y;
    end
  end

  assign nb_out = r_nb;
  assign nc_out = r_nc;
  assign a1_out = r_a1;
  assign a2_out = r_a2;
  assign a3_out = r_a3;
  assign a4_out = r_a4;
  assign y_out  = r_y;

endmodule

// File: tb/tb_mux_4x1.sv
// Bench for mux_4x1: a 1-bit and an 8-bit instance driven in lockstep, checked against a select-indexed model.
module tb_mux_4x1;
  import mux_4x1_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       b;
  logic       c;
  logic [3:0] d1;
  logic [7:0] d8 [4];

  logic       nb1, nc1, y1;
  logic [0:0] a1w [4];
  logic       nb8, nc8;
  logic [7:0] a8w [4];
  logic [7:0] y8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_4x1 #(.WIDTH(1)) dut1 (
    .clk_in (clk), .rst_in (rst),
    .i0_in (d1[0]), .i1_in (d1[1]), .i2_in (d1[2]), .i3_in (d1[3]),
    .b_in (b), .c_in (c),
    .nb_out (nb1), .nc_out (nc1),
    .a1_out (a1w[0]), .a2_out (a1w[1]), .a3_out (a1w[2]), .a4_out (a1w[3]),
    .y_out (y1)
  );

  mux_4x1 #(.WIDTH(8)) dut8 (
    .clk_in (clk), .rst_in (rst),
    .i0_in (d8[0]), .i1_in (d8[1]), .i2_in (d8[2]), .i3_in (d8[3]),
    .b_in (b), .c_in (c),
    .nb_out (nb8), .nc_out (nc8),
    .a1_out (a8w[0]), .a2_out (a8w[1]), .a3_out (a8w[2]), .a4_out (a8w[3]),
    .y_out (y8)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply selects/reset (data already driven), clock once, compare against the model.
  task automatic step(input logic r, input logic [1:0] sel, input string ph);
    logic [3:0] sd1;
    logic [7:0] sd8 [4];
    logic [7:0] e1, e8;
    rst = r;
    {b, c} = sel;
    sd1 = d1;
    for (int unsigned k = 0; k < 4; k++) sd8[k] = d8[k];
    @(posedge clk);
    #1;
    chk({ph, ":nb1"}, {7'b0, nb1}, r ? 8'h00 : {7'b0, ~sel[1]});
    chk({ph, ":nc1"}, {7'b0, nc1}, r ? 8'h00 : {7'b0, ~sel[0]});
    chk({ph, ":nb8"}, {7'b0, nb8}, r ? 8'h00 : {7'b0, ~sel[1]});
    chk({ph, ":nc8"}, {7'b0, nc8}, r ? 8'h00 : {7'b0, ~sel[0]});
    for (int unsigned k = 0; k < 4; k++) begin
      e1 = (!r && sel == k[1:0]) ? {7'b0, sd1[k]} : 8'h00;
      e8 = (!r && sel == k[1:0]) ? sd8[k] : 8'h00;
      chk($sformatf("%s:a%0d_w1", ph, k + 1), {7'b0, a1w[k]}, e1);
      chk($sformatf("%s:a%0d_w8", ph, k + 1), a8w[k], e8);
    end
    chk({ph, ":y1"}, {7'b0, y1}, r ? 8'h00 : {7'b0, sd1[sel]});
    chk({ph, ":y8"}, y8, r ? 8'h00 : sd8[sel]);
  endtask

  task automatic rand_data();
    d1 = 4'($urandom);
    for (int unsigned k = 0; k < 4; k++) d8[k] = 8'($urandom);
  endtask

  initial begin
    logic [1:0] sel;
    bit         rst_done;

    rst = 1'b1;
    b = 1'b0;
    c = 1'b0;
    rand_data();

    // Reset held two edges with arbitrary inputs, then release.
    step(1'b1, 2'($urandom), "rst0");
    rand_data();
    step(1'b1, 2'($urandom), "rst1");
    rand_data();
    step(1'b0, 2'($urandom), "release");

    // Directed pattern i0..i3 = 1,0,1,0 across all four selects.
    d1 = 4'b0101;
    for (int unsigned k = 0; k < 4; k++) d8[k] = (k % 2 == 0) ? 8'hA5 : 8'h5A;
    step(1'b0, SEL_I0, "dir_i0");
    step(1'b0, SEL_I1, "dir_i1");
    step(1'b0, SEL_I2, "dir_i2");
    step(1'b0, SEL_I3, "dir_i3");

    // Exhaustive sweep with one mid-sweep reset on a cycle where y would be 1.
    rst_done = 1'b0;
    for (int unsigned n = 0; n < 64; n++) begin
      d1 = n[3:0];
      sel = n[5:4];
      for (int unsigned k = 0; k < 4; k++) d8[k] = 8'($urandom);
      step(1'b0, sel, "sweep");
      if (!rst_done && n >= 30 && d1[sel]) begin
        step(1'b1, sel, "midrst");
        rst_done = 1'b1;
      end
    end

    // Random traffic with occasional reset pulses.
    for (int unsigned n = 0; n < 200; n++) begin
      rand_data();
      step(($urandom_range(15) == 0), 2'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
